// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath board signal bundle.
// The sequencer is master; the datapath board side is slave.
interface cpu_sequencer_if;
  logic [7:0]  dataio;
  logic        run;
  logic [18:0] ctl;
  logic        sync;
  logic        illegal;
  logic [2:0]  tstate;

  modport master (
    input  dataio, run,
    output ctl, sync, illegal, tstate
  );

  modport slave (
    output dataio, run,
    input  ctl, sync, illegal, tstate
  );
endinterface

// File: rtl/cpu_sequencer.sv
// 6502 datapath timing/control FSM: fetch, decode and one control
// word per clock for NOP, transfers, immediate loads and ADC #imm.
module cpu_sequencer #(
  parameter logic [7:0] RESET_IR = 8'hEA
) (
  input  logic     clk,
  input  logic     clr,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    HALT = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    DEC  = 3'd3,
    IM1  = 3'd4,
    IM2  = 3'd5,
    ALU  = 3'd6
  } state_t;

  localparam logic [18:0] ABLWA    = 19'd1 << 0;
  localparam logic [18:0] ABHWA    = 19'd1 << 1;
  localparam logic [18:0] PCLADLOA = 19'd1 << 2;
  localparam logic [18:0] PCHADHOA = 19'd1 << 3;
  localparam logic [18:0] PCLINC   = 19'd1 << 4;
  localparam logic [18:0] DLWA     = 19'd1 << 5;
  localparam logic [18:0] DLDBOA   = 19'd1 << 6;
  localparam logic [18:0] DBSB     = 19'd1 << 7;
  localparam logic [18:0] ACCWA    = 19'd1 << 8;
  localparam logic [18:0] ACCSBOA  = 19'd1 << 9;
  localparam logic [18:0] XWA      = 19'd1 << 10;
  localparam logic [18:0] XOA      = 19'd1 << 11;
  localparam logic [18:0] YWA      = 19'd1 << 12;
  localparam logic [18:0] YOA      = 19'd1 << 13;
  localparam logic [18:0] PREDBWA  = 19'd1 << 14;
  localparam logic [18:0] PRESBWA  = 19'd1 << 15;
  localparam logic [18:0] SUMS     = 19'd1 << 16;
  localparam logic [18:0] ALUSBOA  = 19'd1 << 17;
  localparam logic [18:0] SALUWA   = 19'd1 << 18;

  localparam logic [18:0] C_ADDR  = ABLWA | ABHWA | PCLADLOA | PCHADHOA;
  localparam logic [18:0] C_FETCH = DLWA | PCLINC;

  state_t     state;
  state_t     nstate;
  logic [7:0] ir;
  logic [7:0] nir;

  function automatic logic is_imm(input logic [7:0] op);
    return op == 8'hA9 || op == 8'hA2 ||
           op == 8'hA0 || op == 8'h69;
  endfunction

  function automatic logic is_one(input logic [7:0] op);
    return op == 8'hEA || op == 8'hAA || op == 8'h8A ||
           op == 8'hA8 || op == 8'h98;
  endfunction

  // Control word for a given state/opcode pair.
  function automatic logic [18:0] ctl_of(
    input state_t s, input logic [7:0] op);
    logic [18:0] c;
    c = '0;
    unique case (s)
      F0:  c = C_ADDR;
      F1:  c = C_FETCH;
      IM1: c = C_FETCH;
      ALU: c = SUMS | ALUSBOA | ACCWA | SALUWA;
      DEC: begin
        unique case (1'b1)
          is_imm(op):   c = C_ADDR;
          op == 8'hAA:  c = ACCSBOA | XWA;
          op == 8'h8A:  c = XOA | ACCWA;
          op == 8'hA8:  c = ACCSBOA | YWA;
          op == 8'h98:  c = YOA | ACCWA;
          default:      c = '0;
        endcase
      end
      IM2: begin
        unique case (1'b1)
          op == 8'hA9: c = DLDBOA | DBSB | ACCWA;
          op == 8'hA2: c = DLDBOA | DBSB | XWA;
          op == 8'hA0: c = DLDBOA | DBSB | YWA;
          op == 8'h69: c = DLDBOA | PREDBWA |
                           ACCSBOA | PRESBWA;
          default:     c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nstate = state;
    nir    = ir;
    unique case (state)
      HALT: nstate = bus.run ? F0 : HALT;
      F0:   nstate = F1;
      F1: begin
        nstate = DEC;
        nir    = bus.dataio;
      end
      DEC: begin
        if (is_imm(ir)) nstate = IM1;
        else nstate = bus.run ? F0 : HALT;
      end
      IM1: nstate = IM2;
      IM2: begin
        if (ir == 8'h69) nstate = ALU;
        else nstate = bus.run ? F0 : HALT;
      end
      ALU:     nstate = bus.run ? F0 : HALT;
      default: nstate = HALT;
    endcase
  end

  // Outputs are registered as the decode of the state being entered,
  // so they always equal a pure function of the current state and IR.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= HALT;
      ir          <= RESET_IR;
      bus.ctl     <= '0;
      bus.sync    <= 1'b1;
      bus.illegal <= 1'b0;
    end else begin
      state       <= nstate;
      ir          <= nir;
      bus.ctl     <= ctl_of(nstate, nir);
      bus.sync    <= nstate == HALT || nstate == F0;
      bus.illegal <= nstate == DEC &&
                     !is_imm(nir) && !is_one(nir);
    end
  end

  assign bus.tstate = state;

endmodule
